exmem_stage: RTL and testbench

Execute-to-memory stage buffer for the MIPS pipeline. Consumes the ALU result and overflow flag, plus the execute-stage control bundle, through a valid/ready handshake. Holds them in a 2-entry skid FIFO so that backpressure from the memory stage never creates a combinational ready path back into execute. Also detects trapping arithmetic overflow (ADD, ADDI, SUB) and captures the exception PC for the exception controller.

---
 rtl/mipspkg.sv | 19 +
 rtl/exmem_fifo2.sv | 76 +++++++
 rtl/exmem_stage.sv | 120 ++++++++++++
 tb/tb_exmem_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mipspkg.sv
// mipspkg: shared MIPS pipeline definitions.
// Holds the datapath width, the register-address width and the packed
// execute-to-memory entry that is carried through the EX/MEM buffer.
package mipspkg;

  localparam int DATAWIDTH    = 32;
  localparam int REGADDRWIDTH = 5;

  typedef struct packed {
    logic [DATAWIDTH-1:0]    result;
    logic [DATAWIDTH-1:0]    writedata;
    logic [REGADDRWIDTH-1:0] writereg;
    logic                    regwrite;
    logic                    memread;
    logic                    memwrite;
    logic [DATAWIDTH-1:0]    pc;
  } exmem_entry_t;

endpackage

// File: rtl/exmem_fifo2.sv
// exmem_fifo2: two-entry FIFO of exmem_entry_t.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset (control only)
//   push_i / wdata_i    write wdata_i at the tail when not full
//   pop_i               advance the head when not empty
//   clear_i             drop all entries; overrides push and pop
//   rdata_o             head entry (unqualified; caller gates with empty_o)
//   full_o, empty_o     occupancy flags, purely registered
module exmem_fifo2
  import mipspkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  exmem_entry_t wdata_i,
  output exmem_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  exmem_entry_t mem_q [2];
  logic         head_q, head_d;
  logic         tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == 2'd0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push_ok) tail_d = ~tail_q;
      if (pop_ok)  head_d = ~head_q;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Stage boundary: occupancy/pointer registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Stage boundary: entry storage (not reset; validity comes from count_q)
  always_ff @(posedge clk) begin
    if (push_ok && !clear_i) mem_q[tail_q] <= wdata_i;
  end

endmodule

// File: rtl/exmem_stage.sv
// exmem_stage: execute-to-memory buffer with trapping-overflow detection.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   ex_valid / ex_ready          execute-side handshake; ex_ready is registered-only
//   ex_result, ex_overflow, ex_trap_en, ex_writedata, ex_writereg,
//   ex_regwrite, ex_memread, ex_memwrite, ex_pc   incoming instruction
//   mem_valid / mem_ready        memory-side handshake for the head entry
//   mem_result ... mem_pc        head-entry fields, zero when mem_valid = 0
//   flush                        discard all buffered entries
//   exc_pending, exc_epc, exc_ack  overflow-exception capture and clear
// Only DATAWIDTH = mipspkg::DATAWIDTH and DEPTH = 2 are supported.
module exmem_stage
  import mipspkg::*;
#(
  parameter int DATAWIDTH = mipspkg::DATAWIDTH,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [DATAWIDTH-1:0] ex_result,
  input  logic                 ex_overflow,
  input  logic                 ex_trap_en,
  input  logic [DATAWIDTH-1:0] ex_writedata,
  input  logic [4:0]           ex_writereg,
  input  logic                 ex_regwrite,
  input  logic                 ex_memread,
  input  logic                 ex_memwrite,
  input  logic [DATAWIDTH-1:0] ex_pc,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic [DATAWIDTH-1:0] mem_result,
  output logic [DATAWIDTH-1:0] mem_writedata,
  output logic [4:0]           mem_writereg,
  output logic                 mem_regwrite,
  output logic                 mem_memread,
  output logic                 mem_memwrite,
  output logic [DATAWIDTH-1:0] mem_pc,
  input  logic                 flush,
  output logic                 exc_pending,
  output logic [DATAWIDTH-1:0] exc_epc,
  input  logic                 exc_ack
);

  exmem_entry_t         wr_entry, head_entry, out_entry;
  logic                 fifo_full, fifo_empty;
  logic                 accept, trap, push, pop;
  logic                 exc_pending_q, exc_pending_d;
  logic [DATAWIDTH-1:0] exc_epc_q, exc_epc_d;

  // Ready comes from the FIFO count only, so mem_ready never reaches ex_ready.
  assign ex_ready  = reset_n && !fifo_full;
  assign mem_valid = reset_n && !fifo_empty;

  assign accept = ex_valid && ex_ready;
  assign trap   = accept && ex_overflow && ex_trap_en;
  // While an exception is pending, younger instructions are squashed.
  assign push   = accept && !trap && !exc_pending_q;
  assign pop    = mem_valid && mem_ready;

  assign wr_entry = '{result:    ex_result,
                      writedata: ex_writedata,
                      writereg:  ex_writereg,
                      regwrite:  ex_regwrite,
                      memread:   ex_memread,
                      memwrite:  ex_memwrite,
                      pc:        ex_pc};

  exmem_fifo2 #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (flush),
    .wdata_i (wr_entry),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_entry     = mem_valid ? head_entry : '0;
  assign mem_result    = out_entry.result;
  assign mem_writedata = out_entry.writedata;
  assign mem_writereg  = out_entry.writereg;
  assign mem_regwrite  = out_entry.regwrite;
  assign mem_memread   = out_entry.memread;
  assign mem_memwrite  = out_entry.memwrite;
  assign mem_pc        = out_entry.pc;

  // The first fault's PC is kept until acknowledged; a trap arriving with the
  // ack replaces it, since the ack retires the old one in the same edge.
  always_comb begin
    exc_pending_d = exc_pending_q;
    exc_epc_d     = exc_epc_q;
    if (trap) begin
      exc_pending_d = 1'b1;
      if (!exc_pending_q || exc_ack) exc_epc_d = ex_pc;
    end else if (exc_ack) begin
      exc_pending_d = 1'b0;
    end
  end

  // Stage boundary: exception capture registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      exc_pending_q <= 1'b0;
      exc_epc_q     <= '0;
    end else begin
      exc_pending_q <= exc_pending_d;
      exc_epc_q     <= exc_epc_d;
    end
  end

  assign exc_pending = exc_pending_q;
  assign exc_epc     = exc_epc_q;

endmodule

// File: tb/tb_exmem_stage.sv
module tb_exmem_stage;
  import mipspkg::*;

  typedef struct {
    exmem_entry_t e;
    bit           lat;
    int           cyc;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic        ex_overflow;
  logic        ex_trap_en;
  logic [31:0] ex_writedata;
  logic [4:0]  ex_writereg;
  logic        ex_regwrite, ex_memread, ex_memwrite;
  logic [31:0] ex_pc;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_result, mem_writedata;
  logic [4:0]  mem_writereg;
  logic        mem_regwrite, mem_memread, mem_memwrite;
  logic [31:0] mem_pc;
  logic        flush;
  logic        exc_pending;
  logic [31:0] exc_epc;
  logic        exc_ack;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  sb_item_t sbq[$];

  exmem_stage dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_result(ex_result), .ex_overflow(ex_overflow), .ex_trap_en(ex_trap_en),
    .ex_writedata(ex_writedata), .ex_writereg(ex_writereg),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_pc(ex_pc),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_result(mem_result), .mem_writedata(mem_writedata), .mem_writereg(mem_writereg),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_pc(mem_pc),
    .flush(flush), .exc_pending(exc_pending), .exc_epc(exc_epc), .exc_ack(exc_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exmem_entry_t mk(input logic [31:0] res, input logic [31:0] pc);
    exmem_entry_t e;
    e.result    = res;
    e.writedata = res ^ 32'hA5A5_0000;
    e.writereg  = res[4:0];
    e.regwrite  = res[0];
    e.memread   = res[1];
    e.memwrite  = res[2];
    e.pc        = pc;
    return e;
  endfunction

  // Presents one instruction and holds it until accepted (bounded).
  task automatic send(input logic [31:0] res, input logic ovf, input logic ten,
                      input logic [31:0] pc, input bit enq, input bit lat);
    exmem_entry_t e;
    sb_item_t     it;
    e = mk(res, pc);
    ex_valid     = 1'b1;
    ex_result    = res;
    ex_overflow  = ovf;
    ex_trap_en   = ten;
    ex_writedata = e.writedata;
    ex_writereg  = e.writereg;
    ex_regwrite  = e.regwrite;
    ex_memread   = e.memread;
    ex_memwrite  = e.memwrite;
    ex_pc        = pc;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ex_ready) begin
        if (enq) begin
          it.e = e; it.lat = lat; it.cyc = cyc + 1;
          sbq.push_back(it);
        end
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_overflow = 1'b0; ex_trap_en = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL send_timeout: got ex_ready=0 for 40 cycles expected 1 (result %h)", res);
    ex_valid = 1'b0; ex_overflow = 1'b0; ex_trap_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every retired head entry against the scoreboard.
  always @(negedge clk) begin
    sb_item_t it;
    if (mem_valid && mem_ready) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got result %h expected none", mem_result);
      end else begin
        it = sbq.pop_front();
        check("mem_entry",
              {24'd0, mem_result, mem_writedata, mem_writereg, mem_regwrite,
               mem_memread, mem_memwrite, mem_pc},
              {24'd0, it.e});
        if (it.lat) check("latency_cycle", cyc, it.cyc);
      end
    end
    if (!mem_valid)
      check("idle_fields_zero",
            {24'd0, mem_result, mem_writedata, mem_writereg, mem_regwrite,
             mem_memread, mem_memwrite, mem_pc}, '0);
  end

  initial begin
    reset_n = 1'b0; ex_valid = 1'b1; ex_result = '0; ex_overflow = 1'b0;
    ex_trap_en = 1'b0; ex_writedata = '0; ex_writereg = '0; ex_regwrite = 1'b0;
    ex_memread = 1'b0; ex_memwrite = 1'b0; ex_pc = '0; mem_ready = 1'b0;
    flush = 1'b0; exc_ack = 1'b0;

    // Reset with ex_valid held high
    idle(2);
    @(negedge clk);
    check("rst_ex_ready", ex_ready, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_exc_pending", exc_pending, 0);
    check("rst_exc_epc", exc_epc, 0);
    @(posedge clk); #1;
    reset_n = 1'b1; ex_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ex_ready", ex_ready, 1);
    @(posedge clk); #1;

    // Streaming, back to back, 1-cycle latency
    mem_ready = 1'b1;
    send(32'h0000_0005, 0, 0, 32'h0040_0000, 1, 1);
    send(32'h0000_000A, 0, 0, 32'h0040_0004, 1, 1);
    idle(3);

    // Backpressure: two absorbed, third waits for drain
    mem_ready = 1'b0;
    send(32'h0000_0011, 0, 0, 32'h0040_0100, 1, 0);
    send(32'h0000_0022, 0, 0, 32'h0040_0104, 1, 0);
    fork
      send(32'h0000_0033, 0, 0, 32'h0040_0108, 1, 0);
      begin
        @(negedge clk);
        check("bp_ex_ready_low", ex_ready, 0);
        check("bp_head_first", mem_result, 32'h0000_0011);
        @(negedge clk);
        check("bp_ex_ready_still_low", ex_ready, 0);
        @(posedge clk); #1;
        mem_ready = 1'b1;
      end
    join
    idle(4);
    check("bp_drained", mem_valid, 0);

    // Trap: not enqueued, EPC captured, later accepts squashed
    send(32'h7FFF_FFFF, 1, 1, 32'h0040_0010, 0, 0);
    @(negedge clk);
    check("trap_pending", exc_pending, 1);
    check("trap_epc", exc_epc, 32'h0040_0010);
    check("trap_not_enq", mem_valid, 0);
    @(posedge clk); #1;
    send(32'h0000_0044, 0, 0, 32'h0040_0014, 0, 0);
    send(32'h8000_0000, 1, 1, 32'h0040_0018, 0, 0);
    @(negedge clk);
    check("trap_epc_held", exc_epc, 32'h0040_0010);
    @(posedge clk); #1;
    exc_ack = 1'b1;
    @(posedge clk); #1;
    exc_ack = 1'b0;
    @(negedge clk);
    check("ack_clears", exc_pending, 0);
    @(posedge clk); #1;
    send(32'h0000_0055, 0, 0, 32'h0040_001C, 1, 1);
    idle(2);

    // Trap with simultaneous ack: new trap wins
    send(32'h7FFF_0000, 1, 1, 32'h0040_0030, 0, 0);
    exc_ack = 1'b1;
    send(32'h7FFF_0001, 1, 1, 32'h0040_0040, 0, 0);
    exc_ack = 1'b0;
    @(negedge clk);
    check("ack_trap_pending", exc_pending, 1);
    check("ack_trap_epc", exc_epc, 32'h0040_0040);
    @(posedge clk); #1;
    exc_ack = 1'b1;
    @(posedge clk); #1;
    exc_ack = 1'b0;

    // Non-trapping overflow is enqueued normally
    send(32'h8000_0006, 1, 0, 32'h0040_0050, 1, 1);
    @(negedge clk);
    check("addu_no_exc", exc_pending, 0);
    @(posedge clk); #1;
    idle(2);

    // Flush with two buffered and an incoming instruction
    mem_ready = 1'b0;
    send(32'h0000_0066, 0, 0, 32'h0040_0060, 1, 0);
    send(32'h0000_0077, 0, 0, 32'h0040_0064, 1, 0);
    flush = 1'b1;
    ex_valid = 1'b1; ex_result = 32'h0000_0088; ex_pc = 32'h0040_0068;
    @(posedge clk); #1;
    flush = 1'b0; ex_valid = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("flush_mem_valid", mem_valid, 0);
    check("flush_ex_ready", ex_ready, 1);
    @(posedge clk); #1;

    // Flush with one buffered and an accepted incoming instruction
    send(32'h0000_0099, 0, 0, 32'h0040_0070, 1, 0);
    flush = 1'b1;
    send(32'h0000_00AA, 0, 0, 32'h0040_0074, 0, 0);
    flush = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("flush_accept_dropped", mem_valid, 0);
    @(posedge clk); #1;

    // Trap accepted during flush still records the exception
    flush = 1'b1;
    send(32'h7000_0000, 1, 1, 32'h0040_0080, 0, 0);
    flush = 1'b0;
    @(negedge clk);
    check("flush_trap_pending", exc_pending, 1);
    check("flush_trap_epc", exc_epc, 32'h0040_0080);
    @(posedge clk); #1;
    exc_ack = 1'b1;
    @(posedge clk); #1;
    exc_ack = 1'b0;

    mem_ready = 1'b1;
    send(32'h0000_00BB, 0, 0, 32'h0040_0090, 1, 1);
    idle(5);
    check("scoreboard_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
